// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit: request size
// encodings, FSM state encoding, byte-lane geometry and a misalignment helper.
package mem_access_pkg;

    localparam int unsigned LANE_W    = 8;
    localparam int unsigned NUM_LANES = 4;

    // Request size encodings; 2'b11 behaves as a word access.
    typedef enum logic [1:0] {
        SizeByte    = 2'b00,
        SizeHalf    = 2'b01,
        SizeWord    = 2'b10,
        SizeWordAlt = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StRmwRead = 3'd2,
        StWrite   = 3'd3,
        StResp    = 3'd4
    } state_e;

    // Half needs addr[0]==0; word needs addr[1:0]==0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = addr_lo[0];
            default: r = (addr_lo != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mau_load_align.sv
// Combinational load alignment: selects the addressed byte/half lane of a
// memory word and sign- or zero-extends it to 32 bits.
module mau_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  size_e       i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [LANE_W-1:0]   w_byte;
    logic [2*LANE_W-1:0] w_half;
    logic                w_sign;

    // Lane selection (little-endian) and extension.
    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        w_sign = 1'b0;
        case (i_size)
            SizeByte: begin
                w_sign = ~i_unsigned & w_byte[LANE_W-1];
                o_data = {{(32 - LANE_W){w_sign}}, w_byte};
            end
            SizeHalf: begin
                w_sign = ~i_unsigned & w_half[2*LANE_W-1];
                o_data = {{(32 - 2 * LANE_W){w_sign}}, w_half};
            end
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the CPU MEM stage and a word-wide data memory.
// Byte/half/word loads with sign/zero extension; sub-word stores are done as
// read-modify-write. Optional misaligned-access trap: define MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [1:0]        reqSize,
    input  logic              reqUnsigned,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [DATA_W-1:0] reqWData,
    output logic              rspValid,
    output logic [DATA_W-1:0] rspRData,
    output logic              rspFault,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memWriteData,
    input  logic [DATA_W-1:0] memReadData
);

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] r_addr;
    // Holds store data; overwritten with the merged word for sub-word stores.
    logic [DATA_W-1:0] r_wdata;
    size_e             r_size;
    logic              r_unsigned;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_merged;
    logic [31:0]       w_load_data;
    logic              w_accept;
    logic              w_misalign;

    assign w_accept = reqValid && (r_state == StIdle);

`ifdef MISALIGN_TRAP_EN
    logic r_fault;
    assign w_misalign = is_misaligned(reqSize, reqAddr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    mau_load_align u_load_align (
        .i_word     (memReadData),
        .i_addr_lo  (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    // State register; async reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_misalign) begin
                        w_next_state = StResp;
                    end else if (!reqWrite) begin
                        w_next_state = StLoad;
                    end else if (reqSize[1]) begin
                        w_next_state = StWrite;
                    end else begin
                        w_next_state = StRmwRead;
                    end
                end
            end
            StLoad:    w_next_state = StResp;
            StRmwRead: w_next_state = StWrite;
            StWrite:   w_next_state = StResp;
            StResp:    w_next_state = StIdle;
            default:   w_next_state = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        reqReady     = (r_state == StIdle);
        memRead      = (r_state == StLoad) || (r_state == StRmwRead);
        memWrite     = (r_state == StWrite);
        rspValid     = (r_state == StResp);
        memAddress   = '0;
        memWriteData = '0;
        if (memRead || memWrite) begin
            memAddress = {r_addr[ADDR_W-1:2], 2'b00};
        end
        if (memWrite) begin
            memWriteData = r_wdata;
        end
`ifdef MISALIGN_TRAP_EN
        rspFault = (r_state == StResp) && r_fault;
`else
        rspFault = 1'b0;
`endif
    end

    assign rspRData = r_rdata;

    // Store merge: replace the addressed lane(s) of the word read back.
    always_comb begin
        w_merged = memReadData;
        if (r_size == SizeByte) begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_wdata[7:0];
                2'd1:    w_merged[15:8]  = r_wdata[7:0];
                2'd2:    w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_size == SizeHalf) begin
            if (r_addr[1]) begin
                w_merged[31:16] = r_wdata[15:0];
            end else begin
                w_merged[15:0] = r_wdata[15:0];
            end
        end
    end

    // Request latch on accept, load result and merged-word capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= SizeByte;
            r_unsigned <= 1'b0;
            r_rdata    <= '0;
`ifdef MISALIGN_TRAP_EN
            r_fault    <= 1'b0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_addr     <= reqAddr;
                        r_wdata    <= reqWData;
                        r_size     <= size_e'(reqSize);
                        r_unsigned <= reqUnsigned;
                        r_rdata    <= '0;
`ifdef MISALIGN_TRAP_EN
                        r_fault    <= w_misalign;
`endif
                    end
                end
                StLoad:    r_rdata <= w_load_data;
                StRmwRead: r_wdata <= w_merged;
                default:   ;
            endcase
        end
    end

endmodule
